// File: rtl/fc_pkg.sv
// Shared state encoding and width helpers for the fc layer controller.
package fc_pkg;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        FLUSH,
        OUTPUT
    } fc_state_t;

    // Address/select width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fc_mod_counter.sv
// Modulo-MOD up counter; wrap flags the increment that returns to zero.
// Latency: count updates on the edge after en; wrap is combinational.
// Backpressure: none, advances only when en is high.
module fc_mod_counter
    import fc_pkg::*;
#(
    parameter int MOD = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       clr,
    output logic [clog2_min1(MOD)-1:0] cnt,
    output logic                       wrap
);

    localparam int W = clog2_min1(MOD);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fc_ctrl.sv
// Sequencer for the fc layer: loads M x-words, issues M MACs per P-lane group, drains lanes.
// Latency: first output_valid M+1 cycles after COMPUTE entry; per group M+1 cycles + P handshakes.
// Backpressure: input_ready only in LOAD; OUTPUT holds state and out_sel until output_ready.
module fc_ctrl
    import fc_pkg::*;
#(
    parameter int M = 6,
    parameter int N = 8,
    parameter int T = 16,
    parameter int P = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         input_valid,
    output logic                         input_ready,
    output logic                         x_wr_en,
    output logic [clog2_min1(M)-1:0]     x_wr_addr,
    output logic [clog2_min1(M)-1:0]     x_rd_addr,
    output logic [clog2_min1(M*N/P)-1:0] w_addr,
    output logic                         mac_en,
    output logic                         mac_clear,
    output logic [clog2_min1(P)-1:0]     out_sel,
    output logic                         output_valid,
    input  logic                         output_ready
);

    localparam int G  = N / P;
    localparam int AW = clog2_min1(M);
    localparam int WW = clog2_min1(M * G);
    localparam int GW = clog2_min1(G);
    localparam int SW = clog2_min1(P);

    generate
        if ((N % P) != 0 || M < 2 || P < 1 || P > N || T < 1) begin : g_param_err
            $error("fc_ctrl: illegal parameters M=%0d N=%0d P=%0d T=%0d", M, N, P, T);
        end
    endgenerate

    fc_state_t       state, state_nxt;
    logic [AW-1:0]   col;
    logic [GW-1:0]   grp;
    logic [SW-1:0]   lane;
    logic            col_wrap, grp_wrap, lane_wrap;
    logic            accept, handshake;
    logic            mac_pipe, clr_pipe;

    // Gating with reset keeps any handshake from completing in the reset cycle.
    assign input_ready  = (state == LOAD) && !reset;
    assign output_valid = (state == OUTPUT) && !reset;
    assign accept       = input_valid && input_ready;
    assign handshake    = output_valid && output_ready;

    assign x_wr_en   = accept;
    assign x_wr_addr = col;
    assign x_rd_addr = col;
    assign w_addr    = WW'(grp) * WW'(M) + WW'(col);
    assign mac_en    = mac_pipe;
    assign mac_clear = clr_pipe;
    assign out_sel   = lane;

    // col counts accepted words in LOAD and the issue index k in COMPUTE.
    fc_mod_counter #(.MOD(M)) u_col (
        .clk   (clk),
        .reset (reset),
        .en    (accept || (state == COMPUTE)),
        .clr   (1'b0),
        .cnt   (col),
        .wrap  (col_wrap)
    );

    fc_mod_counter #(.MOD(G)) u_grp (
        .clk   (clk),
        .reset (reset),
        .en    (lane_wrap),
        .clr   (accept && col_wrap),
        .cnt   (grp),
        .wrap  (grp_wrap)
    );

    fc_mod_counter #(.MOD(P)) u_lane (
        .clk   (clk),
        .reset (reset),
        .en    (handshake),
        .clr   (1'b0),
        .cnt   (lane),
        .wrap  (lane_wrap)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (accept && col_wrap) state_nxt = COMPUTE;
            COMPUTE: if (col_wrap)           state_nxt = FLUSH;
            FLUSH:                           state_nxt = OUTPUT;
            OUTPUT:  if (lane_wrap)          state_nxt = grp_wrap ? LOAD : COMPUTE;
            default:                         state_nxt = LOAD;
        endcase
    end

    // MAC enables trail address issue by one cycle to match the memory read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD;
            mac_pipe <= 1'b0;
            clr_pipe <= 1'b0;
        end else begin
            state    <= state_nxt;
            mac_pipe <= (state == COMPUTE);
            clr_pipe <= (state == COMPUTE) && (col == '0);
        end
    end

endmodule

// File: tb/tb_fc_ctrl.sv
// Bench for fc_ctrl: directed vector table, randomized vectors against a scripted model, resets mid-run.
module tb_fc_ctrl;

    localparam int M = 6;
    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: P=1
    logic       rst0 = 1'b1, iv0 = 1'b0, or0 = 1'b0;
    logic       ir0, we0, me0, mc0, ov0;
    logic [2:0] wa0, ra0;
    logic [5:0] w0;
    logic [0:0] sel0;
    // DUT 1: P=2
    logic       rst1 = 1'b1, iv1 = 1'b0, or1 = 1'b0;
    logic       ir1, we1, me1, mc1, ov1;
    logic [2:0] wa1, ra1;
    logic [4:0] w1;
    logic [0:0] sel1;

    fc_ctrl #(.M(M), .N(N), .T(16), .P(1)) dut0 (
        .clk(clk), .reset(rst0), .input_valid(iv0), .input_ready(ir0),
        .x_wr_en(we0), .x_wr_addr(wa0), .x_rd_addr(ra0), .w_addr(w0),
        .mac_en(me0), .mac_clear(mc0), .out_sel(sel0),
        .output_valid(ov0), .output_ready(or0)
    );

    fc_ctrl #(.M(M), .N(N), .T(16), .P(2)) dut1 (
        .clk(clk), .reset(rst1), .input_valid(iv1), .input_ready(ir1),
        .x_wr_en(we1), .x_wr_addr(wa1), .x_rd_addr(ra1), .w_addr(w1),
        .mac_en(me1), .mac_clear(mc1), .out_sel(sel1),
        .output_valid(ov1), .output_ready(or1)
    );

    int errors = 0;
    int checks = 0;
    int max_w  = 0;
    int a_ir, a_we, a_wa, a_ra, a_w, a_me, a_mc, a_ov, a_sel;

    typedef struct {
        logic r, iv, ordy;
        int   ir, we, wa, ra, w, me, mc, ov, sel;   // -1 = don't care
    } vec_t;
    vec_t tbl[$];

    // One clock: drive inputs after negedge, sample settled outputs 1 time unit later.
    task automatic cyc(input int d, input logic r, input logic iv, input logic ordy);
        @(negedge clk);
        if (d == 0) begin rst0 = r; iv0 = iv; or0 = ordy; end
        else        begin rst1 = r; iv1 = iv; or1 = ordy; end
        #1;
        if (d == 0) begin
            a_ir = int'(ir0); a_we = int'(we0); a_wa = int'(wa0); a_ra = int'(ra0);
            a_w = int'(w0); a_me = int'(me0); a_mc = int'(mc0); a_ov = int'(ov0); a_sel = int'(sel0);
        end else begin
            a_ir = int'(ir1); a_we = int'(we1); a_wa = int'(wa1); a_ra = int'(ra1);
            a_w = int'(w1); a_me = int'(me1); a_mc = int'(mc1); a_ov = int'(ov1); a_sel = int'(sel1);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        if (exp >= 0) begin
            checks++;
            if (act != exp) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
            end
        end
    endtask

    // LOAD phase: M accepted words, write addresses 0..M-1 in acceptance order.
    task automatic load_vec(input int d, input bit rnd);
        int   acc;
        logic iv;
        acc = 0;
        while (acc < M) begin
            iv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc(d, 1'b0, iv, 1'($urandom_range(0, 1)));
            chk("load_in_rdy", a_ir, 1);
            chk("load_out_vld", a_ov, 0);
            chk("load_mac_en", a_me, 0);
            chk("load_mac_clr", a_mc, 0);
            chk("load_wr_en", a_we, int'(iv));
            if (iv) begin
                chk("load_wr_addr", a_wa, acc);
                acc++;
            end
        end
    endtask

    // COMPUTE+FLUSH: cycle c issues k=c for c<M; MAC enable trails by one cycle.
    task automatic compute_grp(input int d, input int g, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            cyc(d, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("cmp_in_rdy", a_ir, 0);
            chk("cmp_wr_en", a_we, 0);
            chk("cmp_out_vld", a_ov, 0);
            chk("cmp_mac_en", a_me, (c >= 1) ? 1 : 0);
            chk("cmp_mac_clr", a_mc, (c == 1) ? 1 : 0);
            if (c < M) begin
                chk("cmp_rd_addr", a_ra, c);
                chk("cmp_w_addr", a_w, g * M + c);
                if (a_w > max_w) max_w = a_w;
            end
        end
    endtask

    // OUTPUT: lanes 0..p-1 in order, each held until output_ready.
    task automatic output_grp(input int d, input int p);
        logic ordy;
        int   n;
        for (int l = 0; l < p; l++) begin
            n = 0;
            do begin
                ordy = (n >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
                cyc(d, 1'b0, 1'($urandom_range(0, 1)), ordy);
                chk("out_vld", a_ov, 1);
                chk("out_sel", a_sel, l);
                chk("out_in_rdy", a_ir, 0);
                chk("out_mac_en", a_me, 0);
                n++;
            end while (!ordy);
        end
    endtask

    task automatic run_vec(input int d, input int p, input bit rnd);
        load_vec(d, rnd);
        for (int g = 0; g < N / p; g++) begin
            compute_grp(d, g, M + 1);
            output_grp(d, p);
        end
    endtask

    initial begin
        // Directed table, P=1: reset, load, group 0, first output, start of group 1.
        tbl.push_back('{1'b1, 1'b1, 1'b1, 0, 0, -1, -1, -1, -1, -1, 0, -1});
        for (int c = 0; c < M; c++)
            tbl.push_back('{1'b0, 1'b1, 1'b1, 1, 1, c, -1, -1, 0, 0, 0, 0});
        for (int k = 0; k < M; k++)
            tbl.push_back('{1'b0, 1'b1, 1'b1, 0, 0, -1, k, k, (k >= 1) ? 1 : 0, (k == 1) ? 1 : 0, 0, -1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 0, 0, -1, -1, -1, 1, 0, 0, -1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 0, 0, -1, -1, -1, 0, 0, 1, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 0, 0, -1, 0, M, 0, 0, 0, -1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 0, 0, -1, 1, M + 1, 1, 1, 0, -1});

        cyc(0, 1'b1, 1'b0, 1'b0);
        cyc(1, 1'b1, 1'b0, 1'b0);
        foreach (tbl[i]) begin
            cyc(0, tbl[i].r, tbl[i].iv, tbl[i].ordy);
            chk($sformatf("tbl%0d_in_rdy", i), a_ir, tbl[i].ir);
            chk($sformatf("tbl%0d_wr_en", i), a_we, tbl[i].we);
            chk($sformatf("tbl%0d_wr_addr", i), a_wa, tbl[i].wa);
            chk($sformatf("tbl%0d_rd_addr", i), a_ra, tbl[i].ra);
            chk($sformatf("tbl%0d_w_addr", i), a_w, tbl[i].w);
            chk($sformatf("tbl%0d_mac_en", i), a_me, tbl[i].me);
            chk($sformatf("tbl%0d_mac_clr", i), a_mc, tbl[i].mc);
            chk($sformatf("tbl%0d_out_vld", i), a_ov, tbl[i].ov);
            chk($sformatf("tbl%0d_out_sel", i), a_sel, tbl[i].sel);
        end

        // Realign, then randomized vectors.
        cyc(0, 1'b1, 1'b0, 1'b0);
        chk("rst_realign_in_rdy", a_ir, 0);
        for (int v = 0; v < 100; v++) run_vec(0, 1, 1'b1);

        // Reset during COMPUTE at k=3.
        load_vec(0, 1'b1);
        compute_grp(0, 0, 3);
        cyc(0, 1'b1, 1'b1, 1'b1);
        chk("rst_cmp_in_rdy", a_ir, 0);
        chk("rst_cmp_wr_en", a_we, 0);
        chk("rst_cmp_out_vld", a_ov, 0);
        run_vec(0, 1, 1'b1);

        // Reset during OUTPUT with lane 0 offered but not taken.
        load_vec(0, 1'b1);
        compute_grp(0, 0, M + 1);
        cyc(0, 1'b1, 1'b1, 1'b1);
        chk("rst_out_out_vld", a_ov, 0);
        chk("rst_out_in_rdy", a_ir, 0);
        run_vec(0, 1, 1'b1);
        cyc(0, 1'b1, 1'b0, 1'b0);

        // P=2: four groups, out_sel 0,1 per group, top weight address 23.
        cyc(1, 1'b1, 1'b0, 1'b0);
        max_w = 0;
        run_vec(1, 2, 1'b0);
        for (int v = 0; v < 3; v++) run_vec(1, 2, 1'b1);
        chk("p2_w_addr_max", max_w, (M * N / 2) - 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
